pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters:
- ADDR_SIZE, default 10: PC/branch-target width.
- REG_SEL, default 5: register-select width.
- MEM_TIMEOUT, default 15: maximum data-memory wait cycles before abort.
REQ-003 Ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  async reset, asserted at 0.
- id_rs1, id_rs2  in  REG_SEL  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- ex_rd  in  REG_SEL  destination of the ID/EX instruction.
- ex_mem_read  in  1  ID/EX instruction is a load.
- mem_branch, mem_jump, mem_alu_zero  in  1  EX/MEM branch, jump and zero flags.
- mem_branch_target  in  ADDR_SIZE  EX/MEM branch target.
- mem_mem_read, mem_mem_write  in  1  EX/MEM memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the stage register.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  clear the stage register.
- redirect_valid  out  1  load redirect_pc into the PC.
- redirect_pc  out  ADDR_SIZE  redirect target.
- mem_err  out  1  one-cycle memory-timeout pulse.
- stall_cycles  out  16  saturating stall-cycle count.

Function
REQ-004 The block SHALL have two FSM states, RUN and MEM_WAIT, and a wait counter wait_cnt of width clog2(MEM_TIMEOUT+1).
REQ-005 mem_access SHALL equal mem_mem_read | mem_mem_write.
REQ-006 taken SHALL equal (mem_branch & mem_alu_zero) | mem_jump.
REQ-007 load_use SHALL equal ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-008 mem_hold SHALL equal mem_access & ~dmem_ready & ~timeout, where timeout = (state == MEM_WAIT) & (wait_cnt == MEM_TIMEOUT).
REQ-009 Priority SHALL be timeout > mem_hold > taken > load_use; all control outputs are combinational from state, wait_cnt and inputs.
REQ-010 While timeout holds, the block SHALL assert:
- ex_mem_flush, mem_wb_flush and mem_err.
- pc_stall, if_id_stall and id_ex_stall.
REQ-011 While mem_hold holds, the block SHALL assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush; redirect_valid SHALL be 0 even if taken, so the redirect is deferred until the hold releases.
REQ-012 When taken holds without timeout or mem_hold, the block SHALL:
- assert redirect_valid with redirect_pc = mem_branch_target;
- assert if_id_flush, id_ex_flush and ex_mem_flush;
- ignore load_use.
REQ-013 When load_use holds alone, the block SHALL assert pc_stall, if_id_stall and id_ex_flush for each cycle it holds (exactly one cycle for an isolated hazard).
REQ-014 redirect_pc SHALL be 0 whenever redirect_valid is 0.
REQ-015 Transition RUN->MEM_WAIT SHALL occur on a clock edge with mem_hold=1, with wait_cnt loaded to 1.
REQ-016 MEM_WAIT->RUN SHALL occur on an edge with dmem_ready=1 or timeout=1, with wait_cnt cleared to 0.
REQ-017 In MEM_WAIT with neither dmem_ready nor timeout, wait_cnt SHALL increment by 1 per cycle and never exceed MEM_TIMEOUT.
REQ-018 If dmem_ready and timeout coincide, timeout SHALL win: access aborted, mem_err=1.
REQ-019 stall_cycles SHALL increment by 1 on every edge where pc_stall=1 and saturate at 16'hFFFF.
REQ-020 With no condition active, all stall, flush, redirect and mem_err outputs SHALL be 0.

Reset
REQ-021 While rst=0, the block SHALL:
- force state=RUN, wait_cnt=0, stall_cycles=0;
- drive all other outputs to 0 regardless of inputs.
REQ-022 Reset asserted mid-MEM_WAIT SHALL abort the wait with no mem_err pulse; the first edge after release starts in RUN.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles=1.
- Taken branch: mem_branch=1, mem_alu_zero=1, target=0x12C -> redirect_valid=1, redirect_pc=0x12C, if_id/id_ex/ex_mem_flush=1 same cycle.
- Memory wait: mem_mem_read=1, dmem_ready low 3 cycles then high -> 3 cycles of stall with mem_wb_flush; state returns to RUN; stall_cycles=3.
- Timeout: mem_mem_write=1, dmem_ready stuck 0 -> mem_err pulses once on the 16th stall cycle with ex_mem_flush=1; then RUN.
- Branch plus wait: mem_jump=1 with a pending access, dmem_ready=0 for 2 cycles -> redirect_valid=0 during the hold, then 1 on the ready cycle.
- Reset mid-wait: rst=0 at wait cycle 4 -> all outputs 0 immediately, stall_cycles=0, no mem_err.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects, and data-memory
// wait handling with a bounded timeout that aborts the access.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; a pending access without ready enters MEM_WAIT
// MEM_WAIT | waiting on data memory; wait_cnt counts cycles spent waiting
module pipeline_ctrl #(
    parameter int ADDR_SIZE   = 10,
    parameter int REG_SEL     = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SEL-1:0]   id_rs1,
    input  logic [REG_SEL-1:0]   id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_SEL-1:0]   ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 mem_branch,
    input  logic                 mem_jump,
    input  logic                 mem_alu_zero,
    input  logic [ADDR_SIZE-1:0] mem_branch_target,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic                 dmem_ready,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_ex_stall,
    output logic                 ex_mem_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 redirect_valid,
    output logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 mem_err,
    output logic [15:0]          stall_cycles
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic mem_access;
    logic taken;
    logic load_use;
    logic timeout;
    logic mem_hold;
    logic rs1_hit;
    logic rs2_hit;

    assign mem_access = mem_mem_read | mem_mem_write;
    assign taken      = (mem_branch & mem_alu_zero) | mem_jump;
    assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use   = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);
    assign timeout    = (state == MEM_WAIT) & (wait_cnt == CNT_MAX);
    assign mem_hold   = mem_access & ~dmem_ready & ~timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_hold) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready || timeout) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs follow priority timeout > mem_hold > taken > load_use; reset forces all low.
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_flush   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_err        = 1'b0;
        if (rst) begin
            if (timeout) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
                mem_err      = 1'b1;
            end else if (mem_hold) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (taken) begin
                redirect_valid = 1'b1;
                redirect_pc    = mem_branch_target;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                ex_mem_flush   = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (pc_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: table vectors, directed multi-cycle scenarios,
// and random traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 15;

    // Expected output vectors, bit order:
    // {pc, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, redirect_valid, mem_err}
    localparam logic [9:0] E_NONE  = 10'b0000000000;
    localparam logic [9:0] E_TO    = 10'b1110001101;
    localparam logic [9:0] E_HOLD  = 10'b1111000100;
    localparam logic [9:0] E_TAKEN = 10'b0000111010;
    localparam logic [9:0] E_LU    = 10'b1100010000;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       jmp;
        logic       zero;
        logic [9:0] tgt;
        logic       mrd;
        logic       mwr;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] exp;
        logic [9:0] exp_pc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read;
    logic       mem_branch, mem_jump, mem_alu_zero;
    logic [9:0] mem_branch_target;
    logic       mem_mem_read, mem_mem_write, dmem_ready;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       redirect_valid, mem_err;
    logic [9:0] redirect_pc;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_wait;
    int m_age;
    int m_stall;

    pipeline_ctrl #(.ADDR_SIZE(10), .REG_SEL(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_alu_zero(mem_alu_zero),
        .mem_branch_target(mem_branch_target),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2,
                               input logic [4:0] rd, input logic ld,
                               input logic br, input logic jmp, input logic zero,
                               input logic [9:0] tgt,
                               input logic mrd, input logic mwr, input logic rdy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.rd = rd; v.ld = ld; v.br = br; v.jmp = jmp; v.zero = zero;
        v.tgt = tgt; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                id_ex_flush, ex_mem_flush, mem_wb_flush, redirect_valid, mem_err};
    endfunction

    task automatic apply(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_rd = v.rd; ex_mem_read = v.ld;
        mem_branch = v.br; mem_jump = v.jmp; mem_alu_zero = v.zero;
        mem_branch_target = v.tgt;
        mem_mem_read = v.mrd; mem_mem_write = v.mwr; dmem_ready = v.rdy;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [9:0] e, input logic [9:0] epc);
        chk(nm, {12'd0, outs(), redirect_pc}, {12'd0, e, epc});
    endtask

    // Reference: outputs from the priority rules and the time already spent waiting.
    task automatic model_eval(input in_t v, output logic [9:0] e, output logic [9:0] epc);
        bit to, acc, hold, tk, lu;
        to   = m_wait && (m_age == MEM_TIMEOUT);
        acc  = v.mrd || v.mwr;
        hold = acc && !v.rdy && !to;
        tk   = (v.br && v.zero) || v.jmp;
        lu   = v.ld && (v.rd != 0) && ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        epc  = '0;
        if (to)        e = E_TO;
        else if (hold) e = E_HOLD;
        else if (tk) begin
            e = E_TAKEN;
            epc = v.tgt;
        end
        else if (lu)   e = E_LU;
        else           e = E_NONE;
    endtask

    task automatic model_step(input in_t v, input logic pcs);
        bit to, hold;
        to   = m_wait && (m_age == MEM_TIMEOUT);
        hold = (v.mrd || v.mwr) && !v.rdy && !to;
        if (!m_wait) begin
            if (hold) begin
                m_wait = 1;
                m_age  = 1;
            end
        end else if (v.rdy || to) begin
            m_wait = 0;
            m_age  = 0;
        end else begin
            m_age++;
        end
        if (pcs && m_stall < 65535) m_stall++;
    endtask

    // Called just after a rising edge; leaves reset released just after the next one.
    task automatic do_reset();
        rst = 1'b0;
        m_wait = 0; m_age = 0; m_stall = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic count_errs(input int max, output int first, output int n, output logic exf);
        first = 0; n = 0; exf = 1'b0;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (mem_err) begin
                n++;
                if (first == 0) begin
                    first = c;
                    exf = ex_mem_flush;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    in_t  idle, idle_rdy, v;
    vec_t tbl[11];
    logic [9:0] e, epc;
    int first, nerr;
    logic exf;

    initial begin
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_rdy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),       E_NONE,  10'h000};
        tbl[1]  = '{mk(3, 7, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0),       E_LU,    10'h000};
        tbl[2]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0),       E_NONE,  10'h000};
        tbl[3]  = '{mk(6, 6, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0),       E_NONE,  10'h000};
        tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 10'h155, 0, 0, 0), E_NONE,  10'h000};
        tbl[5]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 10'h12C, 0, 0, 0), E_TAKEN, 10'h12C};
        tbl[6]  = '{mk(4, 0, 1, 0, 4, 1, 0, 1, 0, 10'h3FF, 0, 0, 0), E_TAKEN, 10'h3FF};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1),       E_NONE,  10'h000};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),       E_HOLD,  10'h000};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 10'h0AA, 1, 0, 0), E_HOLD,  10'h000};
        tbl[10] = '{mk(1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0),       E_NONE,  10'h000};

        // reset state with inputs that would otherwise assert everything
        apply(mk(5, 5, 1, 1, 5, 1, 1, 1, 1, 10'h1FF, 1, 1, 0));
        #2;
        chk_outs("reset_outputs", E_NONE, 10'h000);
        chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        @(posedge clk); #1;
        apply(idle);
        rst = 1'b1;

        for (int k = 0; k < 11; k++) begin
            apply(tbl[k].i);
            @(negedge clk);
            chk_outs($sformatf("table_%0d", k), tbl[k].exp, tbl[k].exp_pc);
            @(posedge clk); #1;
            apply(idle_rdy);
            @(posedge clk); #1;
        end

        // load-use hazard, one cycle
        do_reset();
        apply(mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk_outs("load_use_stall", E_LU, 10'h000);
        @(posedge clk); #1;
        apply(idle);
        @(negedge clk);
        chk_outs("load_use_release", E_NONE, 10'h000);
        chk("load_use_count", {16'd0, stall_cycles}, 32'd1);
        @(posedge clk); #1;

        // taken branch
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 10'h12C, 0, 0, 0));
        @(negedge clk);
        chk_outs("branch_taken", E_TAKEN, 10'h12C);
        @(posedge clk); #1;

        // memory wait of three cycles
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_outs($sformatf("mem_wait_%0d", c), E_HOLD, 10'h000);
            @(posedge clk); #1;
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        @(negedge clk);
        chk_outs("mem_wait_ready", E_NONE, 10'h000);
        @(posedge clk); #1;
        apply(idle);
        chk("mem_wait_count", {16'd0, stall_cycles}, 32'd3);
        // back in RUN: a fresh miss must take the full 16 cycles to time out
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        count_errs(16, first, nerr, exf);
        chk("mem_wait_back_in_run", first, 16);
        apply(idle_rdy);
        @(posedge clk); #1;

        // timeout
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        count_errs(20, first, nerr, exf);
        chk("timeout_cycle", first, 16);
        chk("timeout_pulses", nerr, 1);
        chk("timeout_ex_mem_flush", {31'd0, exf}, 32'd1);
        chk("timeout_stall_count", {16'd0, stall_cycles}, 32'd20);
        apply(idle_rdy);
        @(posedge clk); #1;

        // jump deferred behind a memory hold
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 10'h2A5, 1, 0, 0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_outs($sformatf("jump_hold_%0d", c), E_HOLD, 10'h000);
            @(posedge clk); #1;
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 10'h2A5, 1, 0, 1));
        @(negedge clk);
        chk_outs("jump_release", E_TAKEN, 10'h2A5);
        @(posedge clk); #1;

        // reset during the wait
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst_wait_pre", {31'd0, pc_stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk_outs("rst_wait_outputs", E_NONE, 10'h000);
        chk("rst_wait_count", {16'd0, stall_cycles}, 32'd0);
        @(posedge clk); #1;
        chk_outs("rst_wait_held", E_NONE, 10'h000);
        rst = 1'b1;
        count_errs(16, first, nerr, exf);
        chk("rst_wait_restart", first, 16);
        chk("rst_wait_single_err", nerr, 1);
        apply(idle_rdy);
        @(posedge clk); #1;

        // random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            v.use1 = 1'($urandom);
            v.use2 = 1'($urandom);
            v.ld   = 1'($urandom);
            v.br   = ($urandom_range(0, 3) == 0);
            v.jmp  = ($urandom_range(0, 7) == 0);
            v.zero = 1'($urandom);
            v.tgt  = 10'($urandom);
            v.mrd  = ($urandom_range(0, 3) == 0);
            v.mwr  = ($urandom_range(0, 5) == 0);
            v.rdy  = ($urandom_range(0, 7) == 0);
            apply(v);
            model_eval(v, e, epc);
            @(negedge clk);
            chk_outs("random_outputs", e, epc);
            @(posedge clk);
            model_step(v, e[9]);
            #1;
            chk("random_stall_cycles", {16'd0, stall_cycles}, m_stall);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
